// File: rtl/fir_interp2.sv
// fir_interp2: fixed-coefficient 2x interpolating FIR, h = [1,2,3,4,3,2,1].
// Polyphase form: each accepted sample produces an even phase (taps 1,3,3,1)
// and an odd phase (taps 2,4,2). Both phases are computed at the accept edge.
// The even result goes straight to out_data. The odd result waits in odd_hold.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no output pending; ready for a new sample
// EVEN  | even-phase output presented; waiting for out_ready
// ODD   | odd-phase output presented; a new sample may be accepted as it leaves

module fir_interp2 #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data
);

    localparam int ACC_W = IN_W + 4;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(4);
    localparam logic signed [31:0]      SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic signed [31:0]      SAT_MIN = -(32'sd1 <<< (OUT_W - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } state_t;

    state_t state;

    // The oldest tap (x3 after the shift) is the pre-shift x2, so only three
    // stored samples are needed.
    logic signed [IN_W-1:0]  x0, x1, x2;
    logic signed [OUT_W-1:0] odd_hold;

    logic signed [ACC_W-1:0] e0, e1, e2, e3;
    logic signed [ACC_W-1:0] acc_even, acc_odd;
    logic signed [OUT_W-1:0] even_sat, odd_sat;
    logic                    accept;

    // Round half up by adding 4 before the arithmetic shift, then clamp to OUT_W.
    function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] r;
        logic signed [31:0]      r_ext;
        sum   = acc + RND;
        r     = sum >>> 3;
        r_ext = 32'(r);
        if (r_ext > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (r_ext < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end else begin
            return r_ext[OUT_W-1:0];
        end
    endfunction

    assign in_ready  = (state == IDLE) || ((state == ODD) && out_ready);
    assign out_valid = (state != IDLE);
    assign accept    = in_valid && in_ready;

    // Both polyphase sums, taken over the post-shift line {in_data, x0, x1, x2}.
    always_comb begin
        e0       = ACC_W'(in_data);
        e1       = ACC_W'(x0);
        e2       = ACC_W'(x1);
        e3       = ACC_W'(x2);
        acc_even = e0 + e1 + e1 + e1 + e2 + e2 + e2 + e3;
        acc_odd  = (e0 <<< 1) + (e1 <<< 2) + (e2 <<< 1);
        even_sat = round_sat(acc_even);
        odd_sat  = round_sat(acc_odd);
    end

    // Sequencer, delay line and output register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            x0       <= '0;
            x1       <= '0;
            x2       <= '0;
            odd_hold <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0       <= in_data;
                        x1       <= x0;
                        x2       <= x1;
                        out_data <= even_sat;
                        odd_hold <= odd_sat;
                        state    <= EVEN;
                    end
                end
                EVEN: begin
                    if (out_ready) begin
                        out_data <= odd_hold;
                        state    <= ODD;
                    end
                end
                ODD: begin
                    if (accept) begin
                        x0       <= in_data;
                        x1       <= x0;
                        x2       <= x1;
                        out_data <= even_sat;
                        odd_hold <= odd_sat;
                        state    <= EVEN;
                    end else if (out_ready) begin
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2. Two instances share all inputs: OUT_W=9
// (normal) and OUT_W=6 (saturating). Expected values are hand-computed.

module tb_fir_interp2;

    logic              clk;
    logic              rst_b;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_ready;
    logic              in_ready, in_ready6;
    logic              out_valid, out_valid6;
    logic signed [8:0] out_data;
    logic signed [5:0] out_data6;

    int n_cmp  = 0;
    int n_fail = 0;

    int stim[$];
    int got9[$];
    int got6[$];
    int gaps;

    fir_interp2 #(.IN_W(8), .OUT_W(9)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    fir_interp2 #(.IN_W(8), .OUT_W(6)) dut_sat (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
        .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Feed stim[] and collect outputs until n_out have been taken or the budget expires.
    // mode 0: out_ready always 1; mode 1: out_ready toggles every cycle.
    task automatic run_stream(input int mode, input int n_out);
        int idx = 0;
        int cyc = 0;
        bit started = 0;
        got9.delete();
        got6.delete();
        gaps = 0;
        while (got9.size() < n_out && cyc < 400) begin
            @(negedge clk);
            in_valid  = (idx < stim.size());
            in_data   = (idx < stim.size()) ? 8'(stim[idx]) : 8'sd0;
            out_ready = (mode == 0) ? 1'b1 : ~cyc[0];
            #1;
            if (started && !out_valid) gaps++;
            if (out_valid) started = 1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                got9.push_back(int'(out_data));
                got6.push_back(int'(out_data6));
            end
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++;
        if (out_data !== 9'sd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL after_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_impulse();
        int ev[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        do_reset();
        stim = '{8, 0, 0, 0};
        run_stream(0, 8);
        n_cmp++;
        if (got9.size() != 8) begin n_fail++; $display("FAIL impulse_count got %0d want 8", got9.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got9.size() || got9[i] !== ev[i]) begin
                n_fail++; $display("FAIL impulse[%0d] got %0d want %0d", i, (i < got9.size()) ? got9[i] : -999, ev[i]);
            end
        end
        n_cmp++;
        if (gaps != 0) begin n_fail++; $display("FAIL impulse_continuous got %0d gaps want 0", gaps); end
    endtask

    task automatic test_neg_round();
        int ev[8] = '{0, -1, -1, -2, -1, -1, 0, 0};
        do_reset();
        stim = '{-4, 0, 0, 0};
        run_stream(0, 8);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got9.size() || got9[i] !== ev[i]) begin
                n_fail++; $display("FAIL neground[%0d] got %0d want %0d", i, (i < got9.size()) ? got9[i] : -999, ev[i]);
            end
        end
    endtask

    // DC level v: early outputs ramp (first), then steady; also checks the OUT_W=6 clamp.
    task automatic test_dc(input int v, input int ramp[5], input int sat6);
        int ev;
        do_reset();
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(v);
        run_stream(0, 32);
        n_cmp++;
        if (got9.size() != 32) begin n_fail++; $display("FAIL dc%0d_count got %0d want 32", v, got9.size()); end
        for (int i = 0; i < 32; i++) begin
            ev = (i < 5) ? ramp[i] : v;
            n_cmp++;
            if (i >= got9.size() || got9[i] !== ev) begin
                n_fail++; $display("FAIL dc%0d[%0d] got %0d want %0d", v, i, (i < got9.size()) ? got9[i] : -999, ev);
            end
        end
        for (int i = 6; i < 32; i++) begin
            n_cmp++;
            if (i >= got6.size() || got6[i] !== sat6) begin
                n_fail++; $display("FAIL sat%0d[%0d] got %0d want %0d", v, i, (i < got6.size()) ? got6[i] : -999, sat6);
            end
        end
    endtask

    task automatic test_backpressure();
        int ev[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        do_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'sd8;
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_data = 8'sd0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== 9'sd1) begin
                n_fail++;
                $display("FAIL bp_stall[%0d] got valid=%b ready=%b data=%0d want 1/0/1", c, out_valid, in_ready, out_data);
            end
            @(negedge clk);
        end
        stim = '{0, 0, 0};
        run_stream(0, 8);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got9.size() || got9[i] !== ev[i]) begin
                n_fail++; $display("FAIL bp_seq[%0d] got %0d want %0d", i, (i < got9.size()) ? got9[i] : -999, ev[i]);
            end
        end
    endtask

    task automatic test_toggle();
        int ev[8] = '{2, 4, 5, 6, 3, 0, -1, -2};
        do_reset();
        stim = '{16, -8, 0, 0};
        run_stream(1, 8);
        n_cmp++;
        if (got9.size() != 8) begin n_fail++; $display("FAIL toggle_count got %0d want 8", got9.size()); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got9.size() || got9[i] !== ev[i]) begin
                n_fail++; $display("FAIL toggle[%0d] got %0d want %0d", i, (i < got9.size()) ? got9[i] : -999, ev[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int ev[8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        do_reset();
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 8'sd50;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 9'sd6) begin
            n_fail++; $display("FAIL mid_even got valid=%b data=%0d want 1/6", out_valid, out_data);
        end
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_b = 1'b1;
        stim = '{8, 0, 0, 0};
        run_stream(0, 8);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (i >= got9.size() || got9[i] !== ev[i]) begin
                n_fail++; $display("FAIL mid_seq[%0d] got %0d want %0d", i, (i < got9.size()) ? got9[i] : -999, ev[i]);
            end
        end
    endtask

    initial begin
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_impulse();
        test_neg_round();
        test_dc(100,  '{13, 25, 50, 75, 88}, 31);
        test_dc(-100, '{-12, -25, -50, -75, -87}, -32);
        test_dc(-128, '{-16, -32, -64, -96, -112}, -32);
        test_backpressure();
        test_toggle();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
